// File: rtl/svi_sdram_arb.sv
// svi_sdram_arb: two-port arbiter in front of the SVI-328 SDRAM controller.
// Port A (Z80 CPU) and port B (ROM/cartridge loader) hold level requests. Each
// granted request becomes one rising edge on sd_rd or sd_we. Completion is taken
// from sd_ready, covering both the busy-then-ready case and the same-word read
// shortcut, where sd_ready never drops.
// Optional feature: define SVI_SDRAM_ARB_RR_EN for round-robin arbitration.
// Without it, port A has fixed priority over port B.
//
// Client handshake: the client raises req with we/addr/din stable and keeps it
// high until the one-cycle ack pulse. For reads, dout is valid in the ack cycle
// and holds until the next read ack on that port. If req is still high in the
// cycle after ack, the arbiter treats it as a new request.
module svi_sdram_arb #(
   parameter int AW = 25
) (
   input  logic          clk,
   input  logic          init_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_din,
   output logic [7:0]    a_dout,
   output logic          a_ack,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [7:0]    b_din,
   output logic [7:0]    b_dout,
   output logic          b_ack,
   output logic          sd_rd,
   output logic          sd_we,
   output logic [AW-1:0] sd_addr,
   output logic [15:0]   sd_din,
   output logic [1:0]    sd_wtbt,
   input  logic [15:0]   sd_dout,
   input  logic          sd_ready,
   output logic [2:0]    dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic          gnt_b;     // port being served: 0 = A, 1 = B
   logic          we_q;      // direction of the access in flight
   logic          sel_b;     // port chosen if a grant happens this cycle
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [7:0]    req_din;
   logic [7:0]    unused_dout_hi;

   // The controller returns the addressed byte in [7:0], so the upper byte is not used.
   assign unused_dout_hi = sd_dout[15:8];
   // The controller selects the byte from addr[0] when both wtbt bits are low.
   assign sd_wtbt   = 2'b00;
   assign dbg_state = state;

`ifdef SVI_SDRAM_ARB_RR_EN
   logic ptr_b;              // port that wins a tie next: 0 = A, 1 = B

   // Round-robin: a tie goes to the pointer, and a lone request always wins.
   assign sel_b = b_req & (~a_req | ptr_b);

   // After each completed access, point at the port that was not just served.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         ptr_b <= 1'b0;
      end else if ((state == S_CHECK || state == S_WAIT) && sd_ready) begin
         ptr_b <= ~gnt_b;
      end
   end
`else
   // Fixed priority: port B wins only when port A is not requesting.
   assign sel_b = ~a_req;
`endif

   // Mux the selected client's request fields.
   always_comb begin
      req_we   = a_we;
      req_addr = a_addr;
      req_din  = a_din;
      if (sel_b) begin
         req_we   = b_we;
         req_addr = b_addr;
         req_din  = b_din;
      end
   end

   // Access sequencer: IDLE grant -> ISSUE -> CHECK -> (WAIT) -> DONE -> IDLE.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state   <= S_IDLE;
         gnt_b   <= 1'b0;
         we_q    <= 1'b0;
         sd_rd   <= 1'b0;
         sd_we   <= 1'b0;
         sd_addr <= '0;
         sd_din  <= '0;
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         a_dout  <= '0;
         b_dout  <= '0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               // Waiting for sd_ready also covers controller startup and any
               // access orphaned by a reset.
               if (sd_ready && (a_req || b_req)) begin
                  gnt_b   <= sel_b;
                  we_q    <= req_we;
                  sd_addr <= req_addr;
                  sd_din  <= {req_din, req_din};
                  sd_rd   <= ~req_we;
                  sd_we   <= req_we;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Give the controller one cycle to register the edge.
               state <= S_CHECK;
            end
            S_CHECK, S_WAIT: begin
               // In CHECK, ready still high means a same-word read hit.
               // In WAIT, ready high means the busy period is over.
               if (sd_ready) begin
                  sd_rd <= 1'b0;
                  sd_we <= 1'b0;
                  a_ack <= ~gnt_b;
                  b_ack <= gnt_b;
                  if (!we_q && !gnt_b) a_dout <= sd_dout[7:0];
                  if (!we_q &&  gnt_b) b_dout <= sd_dout[7:0];
                  state <= S_DONE;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_DONE: begin
               // The request lines stay low for DONE and IDLE, so the next
               // access always starts with a clean rising edge.
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_svi_sdram_arb.sv
// tb_svi_sdram_arb: directed and randomized checks of svi_sdram_arb against a
// transaction-level reference model and a small SDRAM controller model.
// Build with SVI_SDRAM_ARB_RR_EN defined to check the round-robin variant.
module tb_svi_sdram_arb;
   localparam int AW = 25;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic init_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [7:0]    a_din, b_din;
   logic [7:0]    a_dout, b_dout;
   logic          a_ack, b_ack;
   logic          sd_rd, sd_we, sd_ready;
   logic [AW-1:0] sd_addr;
   logic [15:0]   sd_din, sd_dout;
   logic [1:0]    sd_wtbt;
   logic [2:0]    dbg_state;

   svi_sdram_arb #(.AW(AW)) dut (
      .clk(clk), .init_n(init_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
      .sd_rd(sd_rd), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
      .sd_dout(sd_dout), .sd_ready(sd_ready), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d state=%0d", name, got, exp, cyc, dbg_state);
      end
   endtask

   // ---------------- SDRAM controller model ----------------
   bit            force_low = 1'b1;  // hold sd_ready low (controller startup)
   int            set_drop  = 0;     // busy length in cycles; 0 picks a random length
   int            hit_mode  = 0;     // 0 never, 1 always, 2 random same-word read hit
   logic [7:0]    mem [int];
   bit            last_valid;
   logic [AW-2:0] last_word;
   int            ctl_cnt;
   bit            ctl_prev, ctl_hit, ctl_pend_rd;
   logic [AW-1:0] ctl_pend_addr;

   function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
      int idx;
      idx = int'(a);
      if (mem.exists(idx)) return mem[idx];
      return 8'((idx * 7 + 3) & 255);
   endfunction

   initial begin
      sd_ready   = 1'b0;
      sd_dout    = 16'h0000;
      ctl_prev   = 1'b0;
      ctl_cnt    = 0;
      last_valid = 1'b0;
      last_word  = '0;
      forever begin
         @(negedge clk);
         if ((sd_rd || sd_we) && !ctl_prev) begin
            ctl_hit = 1'b0;
            if (sd_we) begin
               mem[int'(sd_addr)] = sd_din[7:0];
               last_valid = 1'b0;
            end else begin
               ctl_hit = last_valid && (last_word == sd_addr[AW-1:1]) &&
                         (hit_mode == 1 || (hit_mode == 2 && $urandom_range(0, 1) == 1));
               last_valid = 1'b1;
               last_word  = sd_addr[AW-1:1];
            end
            if (ctl_hit) begin
               sd_dout = {8'($urandom_range(0, 255)), mem_rd(sd_addr)};
            end else begin
               ctl_cnt       = (set_drop != 0) ? set_drop : int'($urandom_range(2, 6));
               sd_ready      = 1'b0;
               ctl_pend_rd   = sd_rd;
               ctl_pend_addr = sd_addr;
            end
         end else if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
               sd_ready = !force_low;
               if (ctl_pend_rd) sd_dout = {8'($urandom_range(0, 255)), mem_rd(ctl_pend_addr)};
            end
         end else begin
            sd_ready = !force_low;
         end
         ctl_prev = sd_rd || sd_we;
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   // The model works on transactions. A grant must appear in a cycle when the
   // arbiter is free, sd_ready was high and some request was high. The ack must
   // come in the first cycle at least two after the edge where ready was seen
   // high going into it.
   bit            m_busy = 1'b0, m_port, m_we, m_turn_b = 1'b0;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_din;
   int            t_edge = 0, ack_cyc = -10;
   logic [7:0]    e_a_dout = 8'h00, e_b_dout = 8'h00;
   int            rd_rises = 0, we_rises = 0, a_acks = 0, b_acks = 0;
   bit            prev_rd = 1'b0, prev_we = 1'b0;
   int            last_edge_cyc = 0, last_ack_cyc = 0;
   logic [15:0]   last_sd_din;
   logic [AW-1:0] last_sd_addr;
   logic [0:0]    grant_log [$];

   function automatic bit pick_b(input bit ar, input bit br, input bit turn_b);
      if (ar && br) begin
`ifdef SVI_SDRAM_ARB_RR_EN
         return turn_b;
`else
         return 1'b0 & turn_b;
`endif
      end
      return br;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sd_rd && !prev_rd) rd_rises++;
         if (sd_we && !prev_we) we_rises++;
         prev_rd = sd_rd;
         prev_we = sd_we;
         check("rd_we_exclusive", 32'(sd_rd && sd_we), 32'd0);
         check("wtbt", 32'(sd_wtbt), 32'd0);
         if (!init_n) begin
            check("rst_ctrl", 32'({sd_rd, sd_we, a_ack, b_ack}), 32'd0);
            check("rst_addr_din", 32'(sd_addr) | 32'(sd_din), 32'd0);
            check("rst_dout", 32'({a_dout, b_dout}), 32'd0);
            m_busy = 1'b0; ack_cyc = -10; m_turn_b = 1'b0;
            e_a_dout = 8'h00; e_b_dout = 8'h00;
         end else begin
            if (!m_busy) begin
               if (cyc >= ack_cyc + 2 && sd_ready && (a_req || b_req)) begin
                  m_port = pick_b(a_req, b_req, m_turn_b);
                  m_we   = m_port ? b_we : a_we;
                  m_addr = m_port ? b_addr : a_addr;
                  m_din  = m_port ? b_din : a_din;
                  check("grant_kind", 32'({sd_rd, sd_we}), 32'({!m_we, m_we}));
                  check("grant_addr", 32'(sd_addr), 32'(m_addr));
                  check("grant_din", 32'(sd_din), 32'({m_din, m_din}));
                  m_busy = 1'b1; t_edge = cyc; last_edge_cyc = cyc;
                  last_sd_din = sd_din; last_sd_addr = sd_addr;
               end else begin
                  check("idle_quiet", 32'({sd_rd, sd_we}), 32'd0);
               end
               check("ack_idle", 32'({a_ack, b_ack}), 32'd0);
            end else if (cyc >= t_edge + 2 && sd_ready) begin
               check("ack_port", 32'({a_ack, b_ack}), m_port ? 32'd1 : 32'd2);
               check("done_drop", 32'({sd_rd, sd_we}), 32'd0);
               if (!m_we && !m_port) e_a_dout = sd_dout[7:0];
               if (!m_we &&  m_port) e_b_dout = sd_dout[7:0];
               m_busy = 1'b0; ack_cyc = cyc; last_ack_cyc = cyc; m_turn_b = !m_port;
               grant_log.push_back(m_port);
               if (m_port) b_acks++; else a_acks++;
            end else begin
               check("hold_kind", 32'({sd_rd, sd_we}), 32'({!m_we, m_we}));
               check("hold_addr", 32'(sd_addr), 32'(m_addr));
               check("hold_din", 32'(sd_din), 32'({m_din, m_din}));
               check("ack_busy", 32'({a_ack, b_ack}), 32'd0);
            end
            check("a_dout", 32'(a_dout), 32'(e_a_dout));
            check("b_dout", 32'(b_dout), 32'(e_b_dout));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge: raise the request, wait for the ack, then drop req.
   task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [7:0] din);
      bit got;
      got = 1'b0;
      if (port) begin b_we = we; b_addr = addr; b_din = din; b_req = 1'b1; end
      else      begin a_we = we; a_addr = addr; a_din = din; a_req = 1'b1; end
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         got = port ? b_ack : a_ack;
      end
      check(port ? "ack_wait_b" : "ack_wait_a", 32'(got), 32'd1);
      if (port) b_req = 1'b0; else a_req = 1'b0;
   endtask

   task automatic client(input bit port, input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         access(port, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)));
      end
   endtask

   // ---------------- directed + random stimulus ----------------
   int r0, w0, a0, b0, gl0, r_rel;
   logic [0:0] exp_q [$];

   initial begin
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = 8'h00;
      mem[32'h101] = 8'h11; mem[32'h100] = 8'h22; mem[32'hABC] = 8'h5A; mem[32'h40] = 8'h77;
      repeat (3) @(negedge clk);
      init_n = 1'b1;
      check("rst_state_rd", 32'(sd_rd), 32'd0);
      check("rst_state_a_dout", 32'(a_dout), 32'd0);

      // Startup: ready held low for 100 cycles with a CPU read pending.
      set_drop = 3;
      fork
         access(1'b0, 1'b0, 25'h0101, 8'h00);
         begin
            repeat (100) @(negedge clk);
            check("startup_no_edge", 32'(rd_rises + we_rises), 32'd0);
            force_low = 1'b0;
         end
      join
      check("startup_one_edge", 32'(rd_rises), 32'd1);
      check("startup_a_dout", 32'(a_dout), 32'h11);

      // Same-word read shortcut: ready never drops, ack two cycles after the edge.
      hit_mode = 1;
      access(1'b0, 1'b0, 25'h0100, 8'h00);
      check("hit_latency", 32'(last_ack_cyc - last_edge_cyc), 32'd2);
      check("hit_a_dout", 32'(a_dout), 32'h22);
      hit_mode = 0;

      // CPU read with six busy cycles.
      set_drop = 6; r0 = rd_rises; b0 = b_acks;
      access(1'b0, 1'b0, 25'h0ABC, 8'h00);
      check("rd6_latency", 32'(last_ack_cyc - last_edge_cyc), 32'd7);
      check("rd6_a_dout", 32'(a_dout), 32'h5A);
      check("rd6_one_edge", 32'(rd_rises - r0), 32'd1);
      check("rd6_no_b_ack", 32'(b_acks - b0), 32'd0);

      // Loader write, then read back through port B.
      set_drop = 4; r0 = rd_rises; w0 = we_rises;
      access(1'b1, 1'b1, 25'h1F000, 8'hC3);
      check("wr_sd_din", 32'(last_sd_din), 32'hC3C3);
      check("wr_sd_addr", 32'(last_sd_addr), 32'h1F000);
      check("wr_one_we_edge", 32'(we_rises - w0), 32'd1);
      check("wr_no_rd_edge", 32'(rd_rises - r0), 32'd0);
      check("wr_latency", 32'(last_ack_cyc - last_edge_cyc), 32'd5);
      set_drop = 2;
      access(1'b1, 1'b0, 25'h1F000, 8'h00);
      check("wr_readback", 32'(b_dout), 32'hC3);
      check("rb_latency", 32'(last_ack_cyc - last_edge_cyc), 32'd3);

      // Both ports requesting continuously for 8 accesses.
      set_drop = 0; hit_mode = 2; a0 = a_acks; b0 = b_acks; gl0 = grant_log.size();
      for (int i = 0; i < 8; i++) begin
`ifdef SVI_SDRAM_ARB_RR_EN
         exp_q.push_back(1'(i % 2));
`else
         exp_q.push_back(1'b0);
`endif
      end
      a_we = 1'b0; a_addr = 25'h10; b_we = 1'b0; b_addr = 25'h20;
      a_req = 1'b1; b_req = 1'b1;
      for (int i = 0; i < 2000 && grant_log.size() - gl0 < 8; i++) @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;
      check("both_count", 32'(grant_log.size() - gl0), 32'd8);
      for (int i = 0; i < 8 && gl0 + i < grant_log.size(); i++)
         check("both_grant_order", 32'(grant_log[gl0 + i]), 32'(exp_q[i]));
`ifdef SVI_SDRAM_ARB_RR_EN
      check("both_b_acks", 32'(b_acks - b0), 32'd4);
`else
      check("both_b_acks", 32'(b_acks - b0), 32'd0);
`endif
      repeat (4) @(negedge clk);

      // Reset during WAIT, then the pending request is reissued.
      set_drop = 10; hit_mode = 0; r0 = rd_rises; r_rel = 0;
      fork
         access(1'b0, 1'b0, 25'h0040, 8'h00);
         begin
            for (int i = 0; i < 200 && rd_rises == r0; i++) @(negedge clk);
            repeat (4) @(negedge clk);
            init_n = 1'b0;
            #1;
            check("rst_mid_rd", 32'(sd_rd), 32'd0);
            check("rst_mid_ack", 32'(a_ack), 32'd0);
            repeat (2) @(negedge clk);
            set_drop = 3;
            r_rel = rd_rises;
            init_n = 1'b1;
         end
      join
      check("rst_reissue_one", 32'(rd_rises - r_rel), 32'd1);
      check("rst_reissue_dout", 32'(a_dout), 32'h77);

      // Randomized traffic from both clients.
      set_drop = 0; hit_mode = 2;
      fork
         client(1'b0, 40);
         client(1'b1, 40);
      join
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
